// File: rtl/fp_unit.sv
// fp_unit: forward-propagation engine.
// Captures a binary image on an accepted do_fp pulse, streams one signed
// weight per (neuron, pixel) from the weight memory, accumulates one dot
// product per output neuron and reports the argmax neuron and its score
// with a single-cycle fp_done pulse.
//
// Ports:
//   clk       - clock, rising edge
//   rst_l     - asynchronous active-low reset
//   do_fp     - start pulse, honoured only in IDLE
//   image_in  - pixel vector, bit p = pixel p
//   w_rd      - weight memory read strobe
//   w_addr    - weight read address, o*IMG_SZ + p
//   w_data    - signed weight, valid one cycle after the w_rd cycle
//   busy      - high from the cycle after acceptance through the fp_done cycle
//   fp_done   - one-cycle completion pulse
//   result    - winning neuron index, held until the next fp_done
//   score     - winning signed sum, held with result
module fp_unit #(
  parameter int IMG_SZ    = 32,
  parameter int NUM_OUT   = 10,
  parameter int W_WIDTH   = 8,
  parameter int ACC_WIDTH = W_WIDTH + $clog2(IMG_SZ) + 1
) (
  input  logic                                  clk,
  input  logic                                  rst_l,
  input  logic                                  do_fp,
  input  logic [IMG_SZ-1:0]                     image_in,
  output logic                                  w_rd,
  output logic [$clog2(NUM_OUT*IMG_SZ)-1:0]     w_addr,
  input  logic [W_WIDTH-1:0]                    w_data,
  output logic                                  busy,
  output logic                                  fp_done,
  output logic [$clog2(NUM_OUT)-1:0]            result,
  output logic signed [ACC_WIDTH-1:0]           score
);

  localparam int AW = $clog2(NUM_OUT*IMG_SZ);
  localparam int PW = $clog2(IMG_SZ);
  localparam int OW = $clog2(NUM_OUT);
  localparam logic [PW-1:0] P_LAST = PW'(IMG_SZ-1);
  localparam logic [OW-1:0] O_LAST = OW'(NUM_OUT-1);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t                       state;
  logic [OW-1:0]                o;
  logic [PW-1:0]                p;
  logic [IMG_SZ-1:0]            image;

  // Return-path copy of the read counters, one cycle behind the strobe
  logic                         ret_vld;
  logic [OW-1:0]                ro;
  logic [PW-1:0]                rp;

  logic signed [ACC_WIDTH-1:0]  acc;
  logic signed [ACC_WIDTH-1:0]  best;
  logic [OW-1:0]                best_idx;

  logic signed [ACC_WIDTH-1:0]  w_ext;
  logic signed [ACC_WIDTH-1:0]  acc_base;
  logic signed [ACC_WIDTH-1:0]  acc_add;
  logic signed [ACC_WIDTH-1:0]  next_acc;
  logic                         take;
  logic signed [ACC_WIDTH-1:0]  new_best;
  logic [OW-1:0]                new_idx;

  // IMG_SZ is a power of two, so {o, p} is exactly o*IMG_SZ + p
  assign w_rd   = (state == RUN);
  assign w_addr = w_rd ? AW'({o, p}) : '0;

  // Accumulate the returning weight; the first pixel of a neuron restarts
  // the sum. Neuron 0 always seeds best, later neurons must beat it strictly
  // so ties stay with the lower index.
  always_comb begin
    w_ext    = {{(ACC_WIDTH-W_WIDTH){w_data[W_WIDTH-1]}}, w_data};
    acc_base = acc;
    if (rp == '0)
      acc_base = '0;
    acc_add = '0;
    if (image[rp])
      acc_add = w_ext;
    next_acc = acc_base + acc_add;
    take     = ret_vld && (rp == P_LAST) && ((ro == '0) || (next_acc > best));
    new_best = best;
    new_idx  = best_idx;
    if (take) begin
      new_best = next_acc;
      new_idx  = ro;
    end
  end

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      state    <= IDLE;
      o        <= '0;
      p        <= '0;
      image    <= '0;
      ret_vld  <= 1'b0;
      ro       <= '0;
      rp       <= '0;
      acc      <= '0;
      best     <= '0;
      best_idx <= '0;
      busy     <= 1'b0;
      fp_done  <= 1'b0;
      result   <= '0;
      score    <= '0;
    end else begin
      ret_vld <= (state == RUN);
      ro      <= o;
      rp      <= p;
      fp_done <= 1'b0;
      if (ret_vld) begin
        acc      <= next_acc;
        best     <= new_best;
        best_idx <= new_idx;
      end
      case (state)
        IDLE: begin
          if (do_fp) begin
            image <= image_in;
            o     <= '0;
            p     <= '0;
            busy  <= 1'b1;
            state <= RUN;
          end
        end
        RUN: begin
          if (p == P_LAST) begin
            p <= '0;
            if (o == O_LAST) begin
              o     <= '0;
              state <= DRAIN;
            end else begin
              o <= o + 1'b1;
            end
          end else begin
            p <= p + 1'b1;
          end
        end
        // The final weight arrives this cycle, so publish the bypassed winner
        DRAIN: begin
          fp_done <= 1'b1;
          result  <= new_idx;
          score   <= new_best;
          state   <= DONE;
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fp_unit.sv
// tb_fp_unit: self-checking bench for fp_unit.
// A behavioural weight memory answers each read one cycle later; a table of
// hand-computed vectors checks argmax/score, latency, read count, address
// order and busy length, followed by hand-written sequences for ignored
// do_fp pulses, back-to-back runs and a mid-run reset.
module tb_fp_unit;

  logic               clk;
  logic               rst_l;
  logic               do_fp;
  logic [31:0]        image_in;
  logic               w_rd;
  logic [8:0]         w_addr;
  logic [7:0]         w_data;
  logic               busy;
  logic               fp_done;
  logic [3:0]         result;
  logic signed [13:0] score;

  int compared;
  int failed;

  logic [7:0] mem [320];

  typedef struct {
    logic [31:0] img;
    int          pat;
    int          exp_res;
    int          exp_score;
  } vec_t;

  vec_t vecs[8];

  fp_unit dut (
    .clk      (clk),
    .rst_l    (rst_l),
    .do_fp    (do_fp),
    .image_in (image_in),
    .w_rd     (w_rd),
    .w_addr   (w_addr),
    .w_data   (w_data),
    .busy     (busy),
    .fp_done  (fp_done),
    .result   (result),
    .score    (score)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Weight memory: data one cycle after the strobe, garbage otherwise
  always @(posedge clk) begin
    if (w_rd) w_data <= mem[w_addr];
    else      w_data <= 8'($urandom);
  end

  task automatic checkOutput(input string name, input int act, input int exp);
    compared++;
    if (act != exp) begin
      failed++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic fill_weights(input int pat);
    for (int o = 0; o < 10; o++) begin
      for (int p = 0; p < 32; p++) begin
        logic [7:0] w;
        case (pat)
          0:       w = 8'($urandom);
          1:       w = (p == 5) ? 8'(o) : 8'd0;
          2:       w = (o == 3) ? 8'hFF : 8'h80;
          3:       w = (o == 2 || o == 7) ? ((p < 8) ? 8'd5 : 8'd0) : 8'd1;
          4:       w = 8'(o - 10);
          5:       w = 8'h80;
          6:       w = 8'h7F;
          default: w = (p < 8) ? ((o == 6) ? 8'd10 : 8'(o)) : 8'd100;
        endcase
        mem[o*32+p] = w;
      end
    end
  endtask

  // One full run: returns fp_done latency, read count, address errors and
  // busy-cycle count. image_in is scrambled right after capture.
  task automatic applyStimulus(input logic [31:0] img, output int lat,
                               output int rds, output int aerr, output int bsy);
    @(negedge clk);
    image_in = img;
    do_fp    = 1'b1;
    @(posedge clk);
    #1;
    do_fp    = 1'b0;
    image_in = ~img;
    lat  = -1;
    rds  = 0;
    aerr = 0;
    bsy  = 0;
    for (int n = 1; n <= 400; n++) begin
      @(negedge clk);
      if (w_rd) begin
        if (w_addr != 9'(rds)) aerr++;
        rds++;
      end
      if (busy) bsy++;
      if (fp_done && lat < 0) lat = n;
      if (lat >= 0 && n >= lat + 2) break;
    end
  endtask

  initial begin
    int lat, rds, aerr, bsy;
    int d1, d2, dcnt, r1, s1, r2, s2;

    compared = 0;
    failed   = 0;
    rst_l    = 1'b1;
    do_fp    = 1'b0;
    image_in = '0;
    for (int i = 0; i < 320; i++) mem[i] = 8'd0;

    vecs[0] = '{32'h0000_0000, 0, 0, 0};
    vecs[1] = '{32'h0000_0020, 1, 9, 9};
    vecs[2] = '{32'hFFFF_FFFF, 2, 3, -32};
    vecs[3] = '{32'hFFFF_FFFF, 3, 2, 40};
    vecs[4] = '{32'hFFFF_FFFF, 4, 9, -32};
    vecs[5] = '{32'hFFFF_FFFF, 5, 0, -4096};
    vecs[6] = '{32'hFFFF_FFFF, 6, 0, 4064};
    vecs[7] = '{32'h0000_00FF, 7, 6, 80};

    // Reset state
    #3 rst_l = 1'b0;
    #1;
    checkOutput("reset busy",    int'(busy),    0);
    checkOutput("reset w_rd",    int'(w_rd),    0);
    checkOutput("reset w_addr",  int'(w_addr),  0);
    checkOutput("reset fp_done", int'(fp_done), 0);
    checkOutput("reset result",  int'(result),  0);
    checkOutput("reset score",   int'(score),   0);
    repeat (2) @(negedge clk);
    rst_l = 1'b1;
    repeat (3) @(negedge clk);
    checkOutput("idle w_rd", int'(w_rd), 0);
    checkOutput("idle busy", int'(busy), 0);

    // Table-driven runs
    for (int v = 0; v < 8; v++) begin
      fill_weights(vecs[v].pat);
      applyStimulus(vecs[v].img, lat, rds, aerr, bsy);
      checkOutput($sformatf("v%0d result", v),  int'(result), vecs[v].exp_res);
      checkOutput($sformatf("v%0d score", v),   int'(score),  vecs[v].exp_score);
      checkOutput($sformatf("v%0d latency", v), lat,  322);
      checkOutput($sformatf("v%0d reads", v),   rds,  320);
      checkOutput($sformatf("v%0d addr errors", v), aerr, 0);
      checkOutput($sformatf("v%0d busy cycles", v), bsy, 322);
    end

    // Ignored do_fp at cycles 100 and 322, re-accept in cycle 323
    fill_weights(1);
    @(negedge clk);
    image_in = 32'h0000_0020;
    do_fp    = 1'b1;
    @(posedge clk);
    #1;
    do_fp = 1'b0;
    d1 = -1; d2 = -1; dcnt = 0; r1 = -1; s1 = -1; r2 = -1; s2 = -1;
    for (int n = 1; n <= 700; n++) begin
      @(negedge clk);
      if (fp_done) begin
        dcnt++;
        if (d1 < 0) begin
          d1 = n; r1 = int'(result); s1 = int'(score);
        end else if (d2 < 0) begin
          d2 = n; r2 = int'(result); s2 = int'(score);
        end
      end
      if (n == 100) begin
        image_in = 32'h0;
        do_fp    = 1'b1;
      end
      if (n == 101) do_fp = 1'b0;
      if (n == 322) do_fp = 1'b1;
      if (n == 324) do_fp = 1'b0;
    end
    checkOutput("b2b done count",  dcnt, 2);
    checkOutput("b2b first done",  d1,   322);
    checkOutput("b2b second done", d2,   645);
    checkOutput("b2b first result", r1, 9);
    checkOutput("b2b first score",  s1, 9);
    checkOutput("b2b second result", r2, 0);
    checkOutput("b2b second score",  s2, 0);

    // Mid-run reset aborts the run with no fp_done
    fill_weights(3);
    applyStimulus(32'hFFFF_FFFF, lat, rds, aerr, bsy);
    checkOutput("pre-abort result", int'(result), 2);
    @(negedge clk);
    image_in = 32'hFFFF_FFFF;
    do_fp    = 1'b1;
    @(posedge clk);
    #1;
    do_fp = 1'b0;
    for (int n = 1; n < 150; n++) @(negedge clk);
    @(negedge clk);
    rst_l = 1'b0;
    #1;
    checkOutput("abort busy",    int'(busy),    0);
    checkOutput("abort w_rd",    int'(w_rd),    0);
    checkOutput("abort w_addr",  int'(w_addr),  0);
    checkOutput("abort fp_done", int'(fp_done), 0);
    checkOutput("abort result",  int'(result),  0);
    checkOutput("abort score",   int'(score),   0);
    repeat (3) @(negedge clk);
    rst_l = 1'b1;
    dcnt = 0;
    for (int n = 0; n < 400; n++) begin
      @(negedge clk);
      if (fp_done) dcnt++;
    end
    checkOutput("abort no done", dcnt, 0);
    fill_weights(4);
    applyStimulus(32'hFFFF_FFFF, lat, rds, aerr, bsy);
    checkOutput("post-reset result",  int'(result), 9);
    checkOutput("post-reset score",   int'(score),  -32);
    checkOutput("post-reset latency", lat, 322);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed);
    $finish;
  end

endmodule
